// File: rtl/fdtd_axi_pkg.sv
// Shared AXI4 constants and write-FSM state type for the FDTD memory ports.
// Holds response codes, the INCR burst code and the word-write state enum.
package fdtd_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR_DATA,
        WR_WAIT_B
    } wr_state_e;

endpackage

// File: rtl/fdtd_mem_word_wr.sv
// Single-word AXI4 write master: one AW + one W beat per request, then B.
// Ports: ACLK/ARESET, AXI4 AW/W/B channels, wr_req/addr/data/be in, wr_gnt/err out.
module fdtd_mem_word_wr
    import fdtd_axi_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int AXI4_ID_WIDTH   = 16,
    parameter int AXI4_USER_WIDTH = 10,
    parameter int AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8
) (
    input  logic                         ACLK,
    input  logic                         ARESET,

    output logic [AXI4_ID_WIDTH-1:0]     AWID_o,
    output logic [AXI4_ADDR_WIDTH-1:0]   AWADDR_o,
    output logic [7:0]                   AWLEN_o,
    output logic [2:0]                   AWSIZE_o,
    output logic [1:0]                   AWBURST_o,
    output logic                         AWLOCK_o,
    output logic [3:0]                   AWCACHE_o,
    output logic [2:0]                   AWPROT_o,
    output logic [3:0]                   AWREGION_o,
    output logic [AXI4_USER_WIDTH-1:0]   AWUSER_o,
    output logic [3:0]                   AWQOS_o,
    output logic                         AWVALID_o,
    input  logic                         AWREADY_i,

    output logic [AXI4_DATA_WIDTH-1:0]   WDATA_o,
    output logic [AXI_STRB_WIDTH-1:0]    WSTRB_o,
    output logic                         WLAST_o,
    output logic [AXI4_USER_WIDTH-1:0]   WUSER_o,
    output logic                         WVALID_o,
    input  logic                         WREADY_i,

    input  logic [AXI4_ID_WIDTH-1:0]     BID_i,
    input  logic [1:0]                   BRESP_i,
    input  logic [AXI4_USER_WIDTH-1:0]   BUSER_i,
    input  logic                         BVALID_i,
    output logic                         BREADY_o,

    input  logic                         wr_req_i,
    input  logic [AXI4_ADDR_WIDTH-3:0]   wr_word_addr_i,
    input  logic [AXI4_DATA_WIDTH-1:0]   wr_data_i,
    input  logic [AXI_STRB_WIDTH-1:0]    wr_be_i,
    output logic                         wr_gnt_o,
    output logic                         wr_err_o
);

    wr_state_e                    r_state;
    wr_state_e                    w_state_nxt;
    logic                         r_aw_pend;
    logic                         r_w_pend;
    logic                         w_aw_pend_nxt;
    logic                         w_w_pend_nxt;
    logic                         w_capture;
    logic [AXI4_ADDR_WIDTH-1:0]   r_awaddr;
    logic [AXI4_DATA_WIDTH-1:0]   r_wdata;
    logic [AXI_STRB_WIDTH-1:0]    r_wstrb;
    logic                         w_unused;

    // Response ID/user carry nothing for a single outstanding write.
    assign w_unused = ^{BID_i, BUSER_i};

    always_comb begin
        w_state_nxt   = r_state;
        w_aw_pend_nxt = r_aw_pend;
        w_w_pend_nxt  = r_w_pend;
        w_capture     = 1'b0;
        unique case (r_state)
            WR_IDLE: begin
                if (wr_req_i) begin
                    w_state_nxt   = WR_ADDR_DATA;
                    w_aw_pend_nxt = 1'b1;
                    w_w_pend_nxt  = 1'b1;
                    w_capture     = 1'b1;
                end
            end
            WR_ADDR_DATA: begin
                // Each channel retires on its own; leave once both are done.
                w_aw_pend_nxt = r_aw_pend & ~AWREADY_i;
                w_w_pend_nxt  = r_w_pend & ~WREADY_i;
                if (!w_aw_pend_nxt && !w_w_pend_nxt) begin
                    w_state_nxt = WR_WAIT_B;
                end
            end
            WR_WAIT_B: begin
                if (BVALID_i) begin
                    w_state_nxt = WR_IDLE;
                end
            end
            default: begin
                w_state_nxt   = WR_IDLE;
                w_aw_pend_nxt = 1'b0;
                w_w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= WR_IDLE;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_aw_pend <= w_aw_pend_nxt;
            r_w_pend  <= w_w_pend_nxt;
            if (w_capture) begin
                r_awaddr <= {wr_word_addr_i, 2'b00};
                r_wdata  <= wr_data_i;
                r_wstrb  <= wr_be_i;
            end
        end
    end

    assign AWID_o     = '0;
    assign AWADDR_o   = r_awaddr;
    assign AWLEN_o    = 8'd0;
    assign AWSIZE_o   = 3'd2;
    assign AWBURST_o  = BURST_INCR;
    assign AWLOCK_o   = 1'b0;
    assign AWCACHE_o  = 4'd0;
    assign AWPROT_o   = 3'd0;
    assign AWREGION_o = 4'd0;
    assign AWUSER_o   = '0;
    assign AWQOS_o    = 4'd0;
    assign AWVALID_o  = r_aw_pend;

    assign WDATA_o    = r_wdata;
    assign WSTRB_o    = r_wstrb;
    assign WLAST_o    = 1'b1;
    assign WUSER_o    = '0;
    assign WVALID_o   = r_w_pend;

    // B is only accepted once both AW and W have completed.
    assign BREADY_o   = (r_state == WR_WAIT_B);

    assign wr_gnt_o   = BVALID_i & BREADY_o;
    assign wr_err_o   = wr_gnt_o &
                        ((BRESP_i == RESP_SLVERR) || (BRESP_i == RESP_DECERR));

endmodule

// File: tb/tb_fdtd_mem_word_wr.sv
// Scoreboard bench for fdtd_mem_word_wr with a small AXI write-slave model.
// Per-request stalls on AW/W, early BVALID, error codes, reset abort, back-to-back.
module tb_fdtd_mem_word_wr;
    import fdtd_axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] AWID_o;
    logic [31:0] AWADDR_o;
    logic [7:0]  AWLEN_o;
    logic [2:0]  AWSIZE_o;
    logic [1:0]  AWBURST_o;
    logic        AWLOCK_o;
    logic [3:0]  AWCACHE_o;
    logic [2:0]  AWPROT_o;
    logic [3:0]  AWREGION_o;
    logic [9:0]  AWUSER_o;
    logic [3:0]  AWQOS_o;
    logic        AWVALID_o;
    logic        AWREADY_i;
    logic [31:0] WDATA_o;
    logic [3:0]  WSTRB_o;
    logic        WLAST_o;
    logic [9:0]  WUSER_o;
    logic        WVALID_o;
    logic        WREADY_i;
    logic [15:0] BID_i;
    logic [1:0]  BRESP_i;
    logic [9:0]  BUSER_i;
    logic        BVALID_i;
    logic        BREADY_o;
    logic        wr_req_i;
    logic [29:0] wr_word_addr_i;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_be_i;
    logic        wr_gnt_o;
    logic        wr_err_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_be[$];
    logic        q_err[$];

    always #5 ACLK = ~ACLK;

    fdtd_mem_word_wr dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .AWID_o         (AWID_o),
        .AWADDR_o       (AWADDR_o),
        .AWLEN_o        (AWLEN_o),
        .AWSIZE_o       (AWSIZE_o),
        .AWBURST_o      (AWBURST_o),
        .AWLOCK_o       (AWLOCK_o),
        .AWCACHE_o      (AWCACHE_o),
        .AWPROT_o       (AWPROT_o),
        .AWREGION_o     (AWREGION_o),
        .AWUSER_o       (AWUSER_o),
        .AWQOS_o        (AWQOS_o),
        .AWVALID_o      (AWVALID_o),
        .AWREADY_i      (AWREADY_i),
        .WDATA_o        (WDATA_o),
        .WSTRB_o        (WSTRB_o),
        .WLAST_o        (WLAST_o),
        .WUSER_o        (WUSER_o),
        .WVALID_o       (WVALID_o),
        .WREADY_i       (WREADY_i),
        .BID_i          (BID_i),
        .BRESP_i        (BRESP_i),
        .BUSER_i        (BUSER_i),
        .BVALID_i       (BVALID_i),
        .BREADY_o       (BREADY_o),
        .wr_req_i       (wr_req_i),
        .wr_word_addr_i (wr_word_addr_i),
        .wr_data_i      (wr_data_i),
        .wr_be_i        (wr_be_i),
        .wr_gnt_o       (wr_gnt_o),
        .wr_err_o       (wr_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            wr_req_i  = 1'b0;
            AWREADY_i = 1'b0;
            WREADY_i  = 1'b0;
            BVALID_i  = 1'b0;
        end
    endtask

    task automatic run_write(input logic [29:0] wa, input logic [31:0] d,
                             input logic [3:0] be, input int aw_st,
                             input int w_st, input logic [1:0] resp,
                             input bit early_b);
        int  aw_n = 0;
        int  w_n = 0;
        int  awv_n = 0;
        int  wv_n = 0;
        int  first_awv = -1;
        int  gnt_cyc = -1;
        int  early_br = 0;
        int  exp_lat;
        bit  aw_done = 0;
        bit  w_done = 0;
        logic ee;
        exp_lat = 2 + ((aw_st > w_st) ? aw_st : w_st);
        q_addr.push_back({wa, 2'b00});
        q_data.push_back(d);
        q_be.push_back(be);
        q_err.push_back(resp == RESP_SLVERR || resp == RESP_DECERR);

        @(negedge ACLK);
        wr_req_i       = 1'b1;
        wr_word_addr_i = wa;
        wr_data_i      = d;
        wr_be_i        = be;
        AWREADY_i      = (aw_st == 0);
        WREADY_i       = (w_st == 0);
        BVALID_i       = 1'b0;
        BRESP_i        = resp;
        #1;
        check("awvalid_c0", AWVALID_o, 0);
        check("gnt_c0", wr_gnt_o, 0);

        for (int cyc = 1; cyc <= 40 && gnt_cyc < 0; cyc++) begin
            @(negedge ACLK);
            AWREADY_i = (cyc > aw_st);
            WREADY_i  = (cyc > w_st);
            BVALID_i  = early_b || (aw_done && w_done);
            BID_i     = 16'hA5A5;
            BUSER_i   = 10'h3FF;
            #1;
            if (BREADY_o && !(aw_done && w_done)) early_br++;
            if (AWVALID_o) begin
                awv_n++;
                if (first_awv < 0) first_awv = cyc;
                check("awaddr", AWADDR_o, q_addr[0]);
            end
            if (AWVALID_o && AWREADY_i) begin
                aw_n++;
                aw_done = 1;
                check("awlen", AWLEN_o, 0);
                check("awsize", AWSIZE_o, 2);
                check("awburst", AWBURST_o, BURST_INCR);
                check("awid", AWID_o, 0);
            end
            if (WVALID_o) begin
                wv_n++;
                check("wdata", WDATA_o, q_data[0]);
                check("wstrb", WSTRB_o, q_be[0]);
                check("wlast", WLAST_o, 1);
            end
            if (WVALID_o && WREADY_i) begin
                w_n++;
                w_done = 1;
            end
            if (wr_gnt_o) begin
                gnt_cyc = cyc;
                ee = q_err.pop_front();
                check("wr_err", wr_err_o, ee);
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
                void'(q_be.pop_front());
            end else begin
                check("err_no_gnt", wr_err_o, 0);
            end
        end

        if (gnt_cyc < 0) begin
            check("timeout", 0, 1);
            void'(q_err.pop_front());
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            void'(q_be.pop_front());
        end
        check("gnt_cycle", gnt_cyc, exp_lat);
        check("aw_beats", aw_n, 1);
        check("w_beats", w_n, 1);
        check("awv_cycles", awv_n, aw_st + 1);
        check("wv_cycles", wv_n, w_st + 1);
        check("first_awv", first_awv, 1);
        check("bready_early", early_br, 0);
    endtask

    initial begin
        ARESET         = 1'b1;
        AWREADY_i      = 1'b0;
        WREADY_i       = 1'b0;
        BID_i          = '0;
        BRESP_i        = RESP_OKAY;
        BUSER_i        = '0;
        BVALID_i       = 1'b0;
        wr_req_i       = 1'b0;
        wr_word_addr_i = '0;
        wr_data_i      = '0;
        wr_be_i        = '0;
        repeat (3) @(negedge ACLK);
        ARESET   = 1'b0;
        BVALID_i = 1'b1;
        #1;
        check("rst_awvalid", AWVALID_o, 0);
        check("rst_wvalid", WVALID_o, 0);
        check("rst_bready", BREADY_o, 0);
        check("rst_gnt", wr_gnt_o, 0);
        check("rst_err", wr_err_o, 0);
        check("rst_awaddr", AWADDR_o, 0);
        check("rst_wdata", WDATA_o, 0);
        check("rst_wstrb", WSTRB_o, 0);
        idle(1);

        run_write(30'h40, 32'hDEADBEEF, 4'hF, 0, 0, RESP_OKAY, 0);
        idle(1);
        run_write(30'h1, 32'hCAFEF00D, 4'h3, 3, 0, RESP_OKAY, 0);
        idle(1);
        run_write(30'h2, 32'h0BADF00D, 4'hC, 0, 2, RESP_OKAY, 1);
        idle(1);
        run_write(30'h3, 32'h11112222, 4'h1, 0, 0, RESP_SLVERR, 0);
        run_write(30'h4, 32'h33334444, 4'h8, 1, 1, RESP_DECERR, 0);
        run_write(30'h5, 32'h55556666, 4'hF, 0, 1, RESP_EXOKAY, 0);
        idle(2);

        @(negedge ACLK);
        wr_req_i       = 1'b1;
        wr_word_addr_i = 30'h55;
        wr_data_i      = 32'hFFFF0000;
        wr_be_i        = 4'hF;
        AWREADY_i      = 1'b1;
        WREADY_i       = 1'b1;
        BVALID_i       = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET   = 1'b1;
        wr_req_i = 1'b0;
        #1;
        check("abort_in_waitb", BREADY_o, 1);
        @(negedge ACLK);
        ARESET   = 1'b0;
        BVALID_i = 1'b1;
        #1;
        check("abort_awvalid", AWVALID_o, 0);
        check("abort_wvalid", WVALID_o, 0);
        check("abort_bready", BREADY_o, 0);
        check("abort_gnt", wr_gnt_o, 0);
        idle(1);
        run_write(30'h20, 32'h12345678, 4'hF, 0, 0, RESP_OKAY, 0);
        idle(1);

        run_write(30'h10, 32'hA0A0A0A0, 4'h5, 0, 0, RESP_OKAY, 0);
        run_write(30'h11, 32'hB1B1B1B1, 4'hA, 0, 0, RESP_OKAY, 0);
        idle(2);

        check("queue_empty", q_addr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
